// File: rtl/dataram_arbiter.sv
// ============================================================================
// dataram_arbiter: two-port round-robin arbiter in front of a single DataRAM
// Rev 1.0
// ============================================================================
`default_nettype none

module dataram_arbiter #(
  parameter int n     = 5,
  parameter int m     = 32,
  parameter int BURST = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Req0,
  input  logic         WR0,
  input  logic [n-1:0] Addr0,
  input  logic [m-1:0] WData0,
  output logic         Gnt0,
  output logic         RValid0,
  output logic [m-1:0] RData0,
  input  logic         Req1,
  input  logic         WR1,
  input  logic [n-1:0] Addr1,
  input  logic [m-1:0] WData1,
  output logic         Gnt1,
  output logic         RValid1,
  output logic [m-1:0] RData1,
  output logic [n-1:0] MemAddr,
  output logic [m-1:0] MemDataIn,
  output logic         MemWR,
  input  logic [m-1:0] MemDataOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] c_BURST = 4'(BURST);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         last_q, last_d;
  logic         rvalid0_q, rvalid1_q;
  logic [m-1:0] rdata0_q, rdata1_q;

  logic         w_acc0, w_acc1;
  logic [3:0]   w_cnt_sat;

  assign Gnt0    = (state_q == OWN0) & ~Reset;
  assign Gnt1    = (state_q == OWN1) & ~Reset;
  assign w_acc0  = Gnt0 & Req0;
  assign w_acc1  = Gnt1 & Req1;
  assign MemWR   = (w_acc0 & WR0) | (w_acc1 & WR1);
  assign RValid0 = rvalid0_q;
  assign RValid1 = rvalid1_q;
  assign RData0  = rdata0_q;
  assign RData1  = rdata1_q;

  always_comb begin
    MemAddr   = '0;
    MemDataIn = '0;
    if (Gnt0) begin
      MemAddr   = Addr0;
      MemDataIn = WData0;
    end else if (Gnt1) begin
      MemAddr   = Addr1;
      MemDataIn = WData1;
    end
  end

  // Count saturates so a late-arriving competitor still gets its turn after one more transfer.
  assign w_cnt_sat = (cnt_q >= c_BURST) ? c_BURST : cnt_q + {3'b000, (w_acc0 | w_acc1)};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (Req0 & Req1) begin
          state_d = last_q ? OWN0 : OWN1;
          last_d  = ~last_q;
          cnt_d   = 4'd0;
        end else if (Req0) begin
          state_d = OWN0;
          last_d  = 1'b0;
          cnt_d   = 4'd0;
        end else if (Req1) begin
          state_d = OWN1;
          last_d  = 1'b1;
          cnt_d   = 4'd0;
        end
      end
      OWN0: begin
        if (Req1 & (~Req0 | (w_cnt_sat == c_BURST))) begin
          state_d = OWN1;
          last_d  = 1'b1;
          cnt_d   = 4'd0;
        end else if (~Req0 & ~Req1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = w_cnt_sat;
        end
      end
      OWN1: begin
        if (Req0 & (~Req1 | (w_cnt_sat == c_BURST))) begin
          state_d = OWN0;
          last_d  = 1'b0;
          cnt_d   = 4'd0;
        end else if (~Req0 & ~Req1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = w_cnt_sat;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rvalid0_q <= w_acc0 & ~WR0;
      rvalid1_q <= w_acc1 & ~WR1;
      if (w_acc0 & ~WR0) rdata0_q <= MemDataOut;
      if (w_acc1 & ~WR1) rdata1_q <= MemDataOut;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dataram_arbiter.sv
// ============================================================================
// tb_dataram_arbiter: randomized and directed bench against a transfer-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dataram_arbiter;

  localparam int BURST = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req0 = 1'b0, WR0 = 1'b0, Req1 = 1'b0, WR1 = 1'b0;
  logic [4:0]  Addr0 = '0, Addr1 = '0;
  logic [31:0] WData0 = '0, WData1 = '0;
  logic        Gnt0, Gnt1, RValid0, RValid1, MemWR;
  logic [31:0] RData0, RData1, MemDataIn, MemDataOut;
  logic [4:0]  MemAddr;

  logic [31:0] ram [32];
  logic        preload = 1'b1;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 none), transfers this tenure, last owner, memory image
  int          m_owner, m_count, m_last;
  logic        m_rv0, m_rv1;
  logic [31:0] m_rd0, m_rd1;
  logic [31:0] ref_mem [32];

  always #5 Clk = ~Clk;

  dataram_arbiter #(.n(5), .m(32), .BURST(BURST)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .WR0(WR0), .Addr0(Addr0), .WData0(WData0),
    .Gnt0(Gnt0), .RValid0(RValid0), .RData0(RData0),
    .Req1(Req1), .WR1(WR1), .Addr1(Addr1), .WData1(WData1),
    .Gnt1(Gnt1), .RValid1(RValid1), .RData1(RData1),
    .MemAddr(MemAddr), .MemDataIn(MemDataIn), .MemWR(MemWR),
    .MemDataOut(MemDataOut)
  );

  assign MemDataOut = ram[MemAddr];

  always @(posedge Clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) ram[i] <= 32'(i);
    end else if (MemWR) begin
      ram[MemAddr] <= MemDataIn;
    end
  end

  task automatic setin(input logic rst, input logic r0, input logic w0, input logic [4:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [4:0] a1, input logic [31:0] d1);
    Reset = rst; Req0 = r0; WR0 = w0; Addr0 = a0; WData0 = d0;
    Req1 = r1; WR1 = w1; Addr1 = a1; WData1 = d1;
  endtask

  task automatic tick();
    int   done;
    logic mine, other, acc;
    @(posedge Clk);
    if (Reset) begin
      m_owner = -1; m_count = 0; m_last = 1;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
    end else begin
      m_rv0 = 1'b0; m_rv1 = 1'b0; acc = 1'b0;
      if (m_owner == 0 && Req0) begin
        acc = 1'b1;
        if (WR0) ref_mem[Addr0] = WData0;
        else begin m_rv0 = 1'b1; m_rd0 = ref_mem[Addr0]; end
      end
      if (m_owner == 1 && Req1) begin
        acc = 1'b1;
        if (WR1) ref_mem[Addr1] = WData1;
        else begin m_rv1 = 1'b1; m_rd1 = ref_mem[Addr1]; end
      end
      if (m_owner < 0) begin
        if (Req0 && Req1) m_owner = 1 - m_last;
        else if (Req0) m_owner = 0;
        else if (Req1) m_owner = 1;
        if (m_owner >= 0) begin m_count = 0; m_last = m_owner; end
      end else begin
        mine  = (m_owner == 0) ? Req0 : Req1;
        other = (m_owner == 0) ? Req1 : Req0;
        done  = m_count + int'(acc);
        if (done > BURST) done = BURST;
        if (other && (!mine || done == BURST)) begin
          m_owner = 1 - m_owner; m_count = 0; m_last = m_owner;
        end else if (!mine && !other) begin
          m_owner = -1; m_count = 0;
        end else begin
          m_count = done;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      setin(1'b1, 1'b1, 1'b1, 5'(k), 32'hA5A5_0000, 1'b1, 1'b1, 5'(k + 1), 32'h5A5A_0000);
      @(negedge Clk);
      checks++;
      if ({Gnt0, Gnt1, MemWR, RValid0, RValid1} !== 5'b0) begin
        errors++; $display("FAIL reset_ctrl got %b want 00000", {Gnt0, Gnt1, MemWR, RValid0, RValid1});
      end
      checks++;
      if ({MemAddr, MemDataIn, RData0, RData1} !== '0) begin
        errors++; $display("FAIL reset_data got %h/%h/%h/%h want 0", MemAddr, MemDataIn, RData0, RData1);
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    setin(1'b0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge Clk);
    checks++;
    if (Gnt0 !== 1'b0) begin errors++; $display("FAIL wr_idle_gnt got %b want 0", Gnt0); end
    tick();
    @(negedge Clk);
    checks++;
    if ({Gnt0, MemWR, MemAddr, MemDataIn} !== {1'b1, 1'b1, 5'd3, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr_accept got %b%b %h %h want 1 1 03 deadbeef", Gnt0, MemWR, MemAddr, MemDataIn);
    end
    tick();
    checks++;
    if (ram[3] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_ram got %h want deadbeef", ram[3]); end
    setin(1'b0, 1'b1, 1'b0, 5'd3, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge Clk);
    checks++;
    if ({Gnt0, MemWR} !== 2'b10) begin errors++; $display("FAIL rd_accept got %b want 10", {Gnt0, MemWR}); end
    tick();
    setin(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge Clk);
    checks++;
    if ({RValid0, RData0} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rd_data got %b %h want 1 deadbeef", RValid0, RData0);
    end
    tick();
    @(negedge Clk);
    checks++;
    if (RValid0 !== 1'b0) begin errors++; $display("FAIL rd_pulse got %b want 0", RValid0); end
    tick();
  endtask

  task automatic test_burst_rotation();
    int want;
    setin(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    for (int k = 0; k < 18; k++) begin
      setin(1'b0, 1'b1, 1'b0, 5'($urandom), 32'd0, 1'b1, 1'b0, 5'($urandom), 32'd0);
      @(negedge Clk);
      want = (k == 0) ? -1 : (((k - 1) / BURST) % 2);
      checks++;
      if ({Gnt0, Gnt1} !== {want == 0, want == 1}) begin
        errors++; $display("FAIL rot_gnt cycle %0d got %b%b want owner %0d", k, Gnt0, Gnt1, want);
      end
      checks++;
      if ({RValid0, RValid1, RData0, RData1} !== {m_rv0, m_rv1, m_rd0, m_rd1}) begin
        errors++; $display("FAIL rot_rdata cycle %0d got %b%b %h %h want %b%b %h %h", k,
                           RValid0, RValid1, RData0, RData1, m_rv0, m_rv1, m_rd0, m_rd1);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    setin(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    for (int k = 0; k < 13; k++) begin
      setin(1'b0, k <= 10, 1'b0, (k == 0) ? 5'd0 : 5'(k - 1), 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      @(negedge Clk);
      checks++;
      if (Gnt1 !== 1'b0) begin errors++; $display("FAIL b2b_gnt1 cycle %0d got %b want 0", k, Gnt1); end
      checks++;
      if (RValid0 !== ((k >= 2) && (k <= 11)) || (RValid0 === 1'b1 && RData0 !== ref_mem[k - 2])) begin
        errors++; $display("FAIL b2b_read cycle %0d got %b %h want %b %h", k, RValid0, RData0,
                           (k >= 2) && (k <= 11), ref_mem[(k >= 2) ? k - 2 : 0]);
      end
      if (RValid0 === 1'b1) nvalid++;
      tick();
    end
    checks++;
    if (nvalid != 10) begin errors++; $display("FAIL b2b_count got %0d want 10", nvalid); end
  endtask

  task automatic test_handover();
    int want [10] = '{-1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    setin(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    for (int k = 0; k < 10; k++) begin
      setin(1'b0, k >= 2, 1'b0, 5'(k), 32'd0, (k <= 2) || (k >= 5), 1'b0, 5'(k + 8), 32'd0);
      @(negedge Clk);
      checks++;
      if ({Gnt0, Gnt1} !== {want[k] == 0, want[k] == 1}) begin
        errors++; $display("FAIL handover cycle %0d got %b%b want owner %0d", k, Gnt0, Gnt1, want[k]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] old7;
    old7 = ref_mem[7];
    setin(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    setin(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd7, 32'h55);
    @(negedge Clk);
    tick();
    setin(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd7, 32'h55);
    @(negedge Clk);
    checks++;
    if ({Gnt1, MemWR} !== 2'b00) begin errors++; $display("FAIL rst_mid_ctrl got %b want 00", {Gnt1, MemWR}); end
    tick();
    checks++;
    if (ram[7] !== old7) begin errors++; $display("FAIL rst_mid_ram got %h want %h", ram[7], old7); end
    setin(1'b0, 1'b1, 1'b0, 5'd1, 32'd0, 1'b1, 1'b0, 5'd2, 32'd0);
    @(negedge Clk);
    tick();
    @(negedge Clk);
    checks++;
    if ({Gnt0, Gnt1} !== 2'b10) begin errors++; $display("FAIL rst_mid_first got %b%b want 10", Gnt0, Gnt1); end
    tick();
  endtask

  task automatic test_random();
    logic       eg0, eg1, ewr;
    logic [4:0] eaddr;
    logic [31:0] edin;
    int         bad = 0;
    for (int k = 0; k < 400; k++) begin
      setin($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom), 5'($urandom), $urandom,
            1'($urandom), 1'($urandom), 5'($urandom), $urandom);
      @(negedge Clk);
      eg0   = !Reset && m_owner == 0;
      eg1   = !Reset && m_owner == 1;
      ewr   = (eg0 && Req0 && WR0) || (eg1 && Req1 && WR1);
      eaddr = eg0 ? Addr0 : (eg1 ? Addr1 : 5'd0);
      edin  = eg0 ? WData0 : (eg1 ? WData1 : 32'd0);
      checks++;
      if ({Gnt0, Gnt1, MemWR, MemAddr, MemDataIn} !== {eg0, eg1, ewr, eaddr, edin}) begin
        errors++; $display("FAIL rnd_mux cycle %0d got %b%b%b %h %h want %b%b%b %h %h", k,
                           Gnt0, Gnt1, MemWR, MemAddr, MemDataIn, eg0, eg1, ewr, eaddr, edin);
      end
      checks++;
      if ({RValid0, RValid1, RData0, RData1} !== {m_rv0, m_rv1, m_rd0, m_rd1}) begin
        errors++; $display("FAIL rnd_read cycle %0d got %b%b %h %h want %b%b %h %h", k,
                           RValid0, RValid1, RData0, RData1, m_rv0, m_rv1, m_rd0, m_rd1);
      end
      tick();
    end
    for (int i = 0; i < 32; i++) if (ram[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rnd_mem got %0d differing words want 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i);
    m_owner = -1; m_count = 0; m_last = 1;
    m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
    @(posedge Clk);
    #1 preload = 1'b0;
    test_reset();
    test_write_read();
    test_burst_rotation();
    test_back_to_back();
    test_handover();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
